// File: rtl/jam_cost_table_pkg.sv
// Shared widths, load-FSM states and index helpers for the cost table and the
// assignment engine that reads it.
package jam_pkg;

    localparam int N    = 8;
    localparam int CW   = 7;
    localparam int SW   = 10;
    localparam int IDXW = 3;
    localparam int LDW  = 2 * IDXW;

    localparam logic [LDW-1:0] LAST_IDX = LDW'(N * N - 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY
    } state_t;

    typedef struct packed {
        logic [IDXW-1:0] w;
        logic [IDXW-1:0] j;
    } cell_t;

    // Row-major beat index: worker in the upper bits, job in the lower bits.
    function automatic cell_t split_idx(input logic [LDW-1:0] idx);
        cell_t c;
        c.w = idx[LDW-1:IDXW];
        c.j = idx[IDXW-1:0];
        return c;
    endfunction

endpackage

// File: rtl/jam_cost_table_if.sv
// Load stream, lookup port and status of the cost table, as seen by the
// engine (master) and the table (slave).
interface jam_cost_table_if;
    import jam_pkg::*;

    logic            CLEAR;
    logic            LD_VALID;
    logic            LD_READY;
    logic [CW-1:0]   LD_DATA;
    logic            LD_LAST;
    logic [IDXW-1:0] W;
    logic [IDXW-1:0] J;
    logic [CW-1:0]   Cost;
    logic            TBL_VALID;
    logic            LD_ERR;
    logic [SW-1:0]   ROW_MIN_SUM;

    modport master (
        output CLEAR, LD_VALID, LD_DATA, LD_LAST, W, J,
        input  LD_READY, Cost, TBL_VALID, LD_ERR, ROW_MIN_SUM
    );

    modport slave (
        input  CLEAR, LD_VALID, LD_DATA, LD_LAST, W, J,
        output LD_READY, Cost, TBL_VALID, LD_ERR, ROW_MIN_SUM
    );

endinterface

// File: rtl/jam_row_min_acc.sv
// Tracks the running minimum of the row being loaded and accumulates the
// per-row minima into a lower bound on any assignment cost.
module jam_row_min_acc
    import jam_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            accept,
    input  logic            clear,
    input  logic [IDXW-1:0] col,
    input  logic [CW-1:0]   data,
    output logic [SW-1:0]   row_min_sum
);

    logic [CW-1:0] row_min_q, row_min_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] beat_min;

    assign beat_min = (data < row_min_q) ? data : row_min_q;

    always_comb begin
        row_min_d = row_min_q;
        sum_d     = sum_q;
        if (accept) begin
            row_min_d = (col == '0) ? data : beat_min;
            if (clear) begin
                sum_d = '0;
            end else if (col == IDXW'(N - 1)) begin
                sum_d = sum_q + SW'(beat_min);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_min_q <= '0;
            sum_q     <= '0;
        end else begin
            row_min_q <= row_min_d;
            sum_q     <= sum_d;
        end
    end

    assign row_min_sum = sum_q;

endmodule

// File: rtl/jam_cost_table.sv
// N x N worker/job cost table: streamed in row-major once per problem, then
// read combinationally so the engine can accumulate cost in the same cycle.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    jam_cost_table_if.slave  bus
);

    state_t          state_q, state_d;
    logic [LDW-1:0]  idx_q, idx_d;
    logic            tbl_valid_q, tbl_valid_d;
    logic            ld_err_q, ld_err_d;

    logic            accept;
    logic            first_beat;
    logic            at_last;
    logic            frame_err;
    cell_t           wr_cell;
    logic [CW-1:0]   row_rd [N];
    logic [SW-1:0]   row_min_sum;

    // Hold ready low during reset so no beat is taken before the FSM is live.
    assign bus.LD_READY = RST_N && (state_q != READY);
    assign accept       = bus.LD_VALID && bus.LD_READY && !bus.CLEAR;
    assign first_beat   = accept && (idx_q == '0);
    assign at_last      = (idx_q == LAST_IDX);
    assign frame_err    = (bus.LD_LAST != at_last);
    assign wr_cell      = split_idx(idx_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tbl_valid_d = tbl_valid_q;
        ld_err_d    = ld_err_q;
        if (bus.CLEAR) begin
            state_d     = EMPTY;
            idx_d       = '0;
            tbl_valid_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY, LOADING: begin
                    if (accept) begin
                        if (first_beat) begin
                            ld_err_d = 1'b0;
                        end
                        if (frame_err) begin
                            state_d     = EMPTY;
                            idx_d       = '0;
                            tbl_valid_d = 1'b0;
                            ld_err_d    = 1'b1;
                        end else if (at_last) begin
                            state_d     = READY;
                            idx_d       = '0;
                            tbl_valid_d = 1'b1;
                        end else begin
                            state_d = LOADING;
                            idx_d   = idx_q + LDW'(1);
                        end
                    end
                end
                READY: begin
                end
                default: begin
                    state_d     = EMPTY;
                    idx_d       = '0;
                    tbl_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= EMPTY;
            idx_q       <= '0;
            tbl_valid_q <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tbl_valid_q <= tbl_valid_d;
            ld_err_q    <= ld_err_d;
        end
    end

    // One flop row per worker; contents need no reset since reads are gated
    // by tbl_valid_q. Erroneous beats are still written but never exposed.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        logic [CW-1:0] row_q [N];

        always_ff @(posedge CLK) begin
            if (accept && (wr_cell.w == IDXW'(gi))) begin
                row_q[wr_cell.j] <= bus.LD_DATA;
            end
        end

        assign row_rd[gi] = row_q[bus.J];
    end

    assign bus.Cost = tbl_valid_q ? row_rd[bus.W] : '0;

    jam_row_min_acc u_row_min (
        .clk         (CLK),
        .rst_n       (RST_N),
        .accept      (accept),
        .clear       (first_beat),
        .col         (wr_cell.j),
        .data        (bus.LD_DATA),
        .row_min_sum (row_min_sum)
    );

    assign bus.TBL_VALID   = tbl_valid_q;
    assign bus.LD_ERR      = ld_err_q;
    assign bus.ROW_MIN_SUM = row_min_sum;

endmodule
